// File: rtl/disp_scan_arb_pkg.sv
// Shared constants for the 4-digit display scanner: segment codes, idle
// pin levels and the source identifier used by the arbiter.
package uec_disp_pkg;

  localparam int N_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} codes, index = hex digit (F leftmost, 0 rightmost).
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/disp_scan_arb_if.sv
// Two-source write port of the display scanner.
// A source transfers on a cycle where its valid and ready are both high; it
// holds valid, data and dp stable until then and may drop valid to withdraw.
interface disp_scan_arb_if;

  logic        valid_a;
  logic [15:0] data_a;
  logic [3:0]  dp_a;
  logic        ready_a;
  logic        valid_b;
  logic [15:0] data_b;
  logic [3:0]  dp_b;
  logic        ready_b;

  modport master (
    output valid_a, data_a, dp_a, valid_b, data_b, dp_b,
    input  ready_a, ready_b
  );

  modport slave (
    input  valid_a, data_a, dp_a, valid_b, data_b, dp_b,
    output ready_a, ready_b
  );

endinterface

// File: rtl/disp_scan_arb_hex7seg_dec.sv
// Nibble to active-low 7-segment code, purely combinational.
module hex7seg_dec
  import uec_disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_HEX[i_nib];

endmodule

// File: rtl/disp_scan_arb.sv
// Shares the 4-digit 7-segment display between two requesters: round-robin
// arbitration into a pending buffer, frame-aligned commit, blanked digit scan.
module disp_scan_arb
  import uec_disp_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 64,
  parameter int LZ_BLANK  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dbg_mode,
  disp_scan_arb_if.slave   src,
  output logic             owner_b,
  output logic             frame_tick,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int DIGIT_CYC = CLK_HZ / SCAN_HZ;
  localparam int CNT_W     = $clog2(DIGIT_CYC);
  localparam int IDX_W     = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_pend;
  logic [15:0]      r_pend_val;
  logic [3:0]       r_pend_dp;
  src_e             r_pend_id;
  src_e             r_rr;
  logic [15:0]      r_act_val;
  logic [3:0]       r_act_dp;
  logic             r_owner_b;
  logic             r_frame_tick;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic       w_base_a, w_base_b, w_clash;
  logic       w_grant_a, w_grant_b;
  logic       w_last, w_lz_hide, w_blank;
  logic [3:0] w_nib;
  logic [6:0] w_seg;

  // Loser of a same-cycle clash sees ready low; reset leaves readies unforced.
  assign w_base_a    = ~r_pend & ~dbg_mode;
  assign w_base_b    = ~r_pend;
  assign w_clash     = rst & src.valid_a & w_base_a & src.valid_b & w_base_b;
  assign src.ready_a = w_base_a & ~(w_clash & (r_rr == SRC_B));
  assign src.ready_b = w_base_b & ~(w_clash & (r_rr == SRC_A));
  assign w_grant_a   = src.valid_a & src.ready_a;
  assign w_grant_b   = src.valid_b & src.ready_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend     <= 1'b0;
      r_pend_val <= 16'h0000;
      r_pend_dp  <= 4'h0;
      r_pend_id  <= SRC_A;
      r_rr       <= SRC_A;
      r_act_val  <= 16'h0000;
      r_act_dp   <= 4'h0;
      r_owner_b  <= 1'b0;
    end else if (r_frame_tick && r_pend) begin
      r_act_val <= r_pend_val;
      r_act_dp  <= r_pend_dp;
      r_owner_b <= (r_pend_id == SRC_B);
      r_pend    <= 1'b0;
    end else if (w_grant_a || w_grant_b) begin
      r_pend     <= 1'b1;
      r_pend_val <= w_grant_b ? src.data_b : src.data_a;
      r_pend_dp  <= w_grant_b ? src.dp_b : src.dp_a;
      r_pend_id  <= w_grant_b ? SRC_B : SRC_A;
      r_rr       <= w_grant_b ? SRC_A : SRC_B;
    end
  end

  assign w_last = (r_cnt == CNT_LAST);
  assign w_nib  = r_act_val[{r_idx, 2'b00} +: 4];

  // A digit above 0 is hidden when it and every digit left of it are zero.
  always_comb begin
    w_lz_hide = 1'b0;
    if (LZ_BLANK != 0) begin
      case (r_idx)
        2'd1:    w_lz_hide = (r_act_val[15:4] == 12'h000);
        2'd2:    w_lz_hide = (r_act_val[15:8] == 8'h00);
        2'd3:    w_lz_hide = (r_act_val[15:12] == 4'h0);
        default: w_lz_hide = 1'b0;
      endcase
    end
  end

  assign w_blank = (r_cnt < CNT_BLANK) | w_lz_hide;

  hex7seg_dec u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_frame_tick <= 1'b0;
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
    end else begin
      r_cnt        <= w_last ? '0 : r_cnt + 1'b1;
      r_idx        <= w_last ? r_idx + 1'b1 : r_idx;
      r_frame_tick <= w_last && (r_idx == IDX_LAST);
      r_an         <= w_blank ? AN_OFF : ~(4'b0001 << r_idx);
      r_seg        <= w_blank ? SEG_OFF : w_seg;
      r_dp         <= w_blank ? 1'b1 : ~r_act_dp[r_idx];
    end
  end

  assign owner_b    = r_owner_b;
  assign frame_tick = r_frame_tick;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;

endmodule

// File: tb/tb_disp_scan_arb.sv
// Directed bench for disp_scan_arb with a 10-cycle digit slot and 2-cycle blank;
// a second instance is built with leading-zero blanking enabled.
module tb_disp_scan_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_mode, dbg_mode_lz;
  logic        owner_b, frame_tick, dp;
  logic        owner_b_lz, frame_tick_lz, dp_lz;
  logic [3:0]  an, an_lz;
  logic [6:0]  seg, seg_lz;
  int          n_tests = 0;
  int          n_fail  = 0;

  disp_scan_arb_if if_m ();
  disp_scan_arb_if if_lz ();

  always #5 clk = ~clk;

  disp_scan_arb #(.CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(2), .LZ_BLANK(0)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .dbg_mode   (dbg_mode),
    .src        (if_m.slave),
    .owner_b    (owner_b),
    .frame_tick (frame_tick),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  disp_scan_arb #(.CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(2), .LZ_BLANK(1)) u_dut_lz (
    .clk        (clk),
    .rst        (rst),
    .dbg_mode   (dbg_mode_lz),
    .src        (if_lz.slave),
    .owner_b    (owner_b_lz),
    .frame_tick (frame_tick_lz),
    .an         (an_lz),
    .seg        (seg_lz),
    .dp         (dp_lz)
  );

  localparam logic [11:0] PINS_OFF = {4'hF, 7'h7F, 1'b1};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  function automatic logic [11:0] pins(input bit lz);
    return lz ? {an_lz, seg_lz, dp_lz} : {an, seg, dp};
  endfunction

  function automatic logic [1:0] rdy();
    return {if_m.ready_a, if_m.ready_b};
  endfunction

  task automatic wait_ft(input bit lz, input string tag);
    int   n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      hit = lz ? frame_tick_lz : frame_tick;
    end
    chk(tag, 16'(hit), 16'h0001);
  endtask

  // Called at frame_tick (at=0) or one cycle later (at=1); returns at frame_tick+33.
  task automatic check_frame(input bit lz, input string tag, input int at,
                             input logic [27:0] segs, input logic [3:0] dps,
                             input logic [3:0] lit);
    logic [3:0]  m;
    logic [11:0] exp;
    for (int d = 0; d < 4; d++) begin
      step((d == 0) ? (1 - at) : 8);
      chk($sformatf("%s_blank%0d", tag, d), 16'(pins(lz)), 16'(PINS_OFF));
      step(2);
      m   = 4'b0001 << d;
      exp = lit[d] ? {~m, segs[d*7 +: 7], ~dps[d]} : PINS_OFF;
      chk($sformatf("%s_dig%0d", tag, d), 16'(pins(lz)), 16'(exp));
    end
  endtask

  initial begin
    rst = 1'b0;
    dbg_mode = 1'b1;
    dbg_mode_lz = 1'b0;
    if_m.valid_a = 1'b0; if_m.data_a = 16'h0; if_m.dp_a = 4'h0;
    if_m.valid_b = 1'b0; if_m.data_b = 16'h0; if_m.dp_b = 4'h0;
    if_lz.valid_a = 1'b0; if_lz.data_a = 16'h0; if_lz.dp_a = 4'h0;
    if_lz.valid_b = 1'b0; if_lz.data_b = 16'h0; if_lz.dp_b = 4'h0;

    // Reset values
    step(2); #1;
    chk("rst_pins", 16'(pins(0)), 16'(PINS_OFF));
    chk("rst_ft_owner", 16'({frame_tick, owner_b}), 16'h0000);
    chk("rst_ready_dbg", 16'(rdy()), 16'h0001);
    dbg_mode = 1'b0; #1;
    chk("rst_ready", 16'(rdy()), 16'h0003);
    @(negedge clk) rst = 1'b1;

    // 1: idle scan of 0000, frame period 40
    wait_ft(0, "t1_ft");
    check_frame(0, "t1", 0, {4{7'h40}}, 4'h0, 4'hF);
    chk("t1_owner", 16'(owner_b), 16'h0000);
    step(7);
    chk("t1_period", 16'(frame_tick), 16'h0001);
    step(1);
    chk("t1_pulse", 16'(frame_tick), 16'h0000);

    // 3: same-cycle clash, pointer at A, then B wins the re-offer
    if_m.valid_a = 1'b1; if_m.data_a = 16'h3456; if_m.dp_a = 4'h0;
    if_m.valid_b = 1'b1; if_m.data_b = 16'h789A; if_m.dp_b = 4'b1000;
    #1 chk("t3_clash_ready", 16'(rdy()), 16'h0002);
    step(1);
    if_m.valid_a = 1'b0;
    #1 chk("t3_pend_ready", 16'(rdy()), 16'h0000);
    wait_ft(0, "t3_ft1");
    chk("t3_ft1_ready", 16'(rdy()), 16'h0000);
    step(1);
    chk("t3_owner_a", 16'(owner_b), 16'h0000);
    if_m.valid_a = 1'b1; if_m.data_a = 16'h1111;
    #1 chk("t3_rr_ready", 16'(rdy()), 16'h0001);
    check_frame(0, "t3a", 1, {7'h30, 7'h19, 7'h12, 7'h02}, 4'h0, 4'hF);
    if_m.valid_a = 1'b0; if_m.valid_b = 1'b0;
    #1 chk("t3_bpend_ready", 16'(rdy()), 16'h0000);
    wait_ft(0, "t3_ft2");
    step(1);
    chk("t3_owner_b", 16'(owner_b), 16'h0001);
    chk("t3_ready_back", 16'(rdy()), 16'h0003);
    check_frame(0, "t3b", 1, {7'h78, 7'h00, 7'h10, 7'h08}, 4'b1000, 4'hF);

    // 2: A writes 0x12AF mid-frame
    wait_ft(0, "t2_ft0");
    step(15);
    if_m.valid_a = 1'b1; if_m.data_a = 16'h12AF; if_m.dp_a = 4'b0001;
    #1 chk("t2_ready_pre", 16'(if_m.ready_a), 16'h0001);
    step(1);
    if_m.valid_a = 1'b0;
    #1 chk("t2_ready_low", 16'(if_m.ready_a), 16'h0000);
    wait_ft(0, "t2_ft1");
    chk("t2_ft_ready", 16'(if_m.ready_a), 16'h0000);
    step(1);
    chk("t2_ready_rise", 16'(if_m.ready_a), 16'h0001);
    chk("t2_owner", 16'(owner_b), 16'h0000);
    check_frame(0, "t2", 1, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b0001, 4'hF);

    // 4: debug mode locks out A
    dbg_mode = 1'b1;
    if_m.valid_a = 1'b1; if_m.data_a = 16'h1111; if_m.dp_a = 4'h0;
    #1 chk("t4_dbg_ready", 16'(rdy()), 16'h0001);
    step(3);
    chk("t4_a_held", 16'(rdy()), 16'h0001);
    if_m.valid_b = 1'b1; if_m.data_b = 16'hBEEF; if_m.dp_b = 4'h0;
    #1 chk("t4_b_ready", 16'(rdy()), 16'h0001);
    step(1);
    if_m.valid_b = 1'b0;
    #1 chk("t4_b_pend", 16'(rdy()), 16'h0000);
    wait_ft(0, "t4_ft1");
    step(1);
    chk("t4_owner_b", 16'(owner_b), 16'h0001);
    chk("t4_ready_dbg", 16'(rdy()), 16'h0001);
    check_frame(0, "t4b", 1, {7'h03, 7'h06, 7'h06, 7'h0E}, 4'h0, 4'hF);
    dbg_mode = 1'b0;
    #1 chk("t4_a_free", 16'(rdy()), 16'h0003);
    step(1);
    if_m.valid_a = 1'b0;
    #1 chk("t4_a_pend", 16'(rdy()), 16'h0000);
    wait_ft(0, "t4_ft2");
    step(1);
    chk("t4_owner_a", 16'(owner_b), 16'h0000);
    check_frame(0, "t4a", 1, {4{7'h79}}, 4'h0, 4'hF);

    // 5: leading-zero blanking on 0x0005
    if_lz.valid_a = 1'b1; if_lz.data_a = 16'h0005; if_lz.dp_a = 4'h0;
    #1 chk("t5_ready", 16'(if_lz.ready_a), 16'h0001);
    step(1);
    if_lz.valid_a = 1'b0;
    wait_ft(1, "t5_ft");
    step(1);
    chk("t5_owner", 16'(owner_b_lz), 16'h0000);
    check_frame(1, "t5", 1, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'h0, 4'b0001);

    // 6: reset during digit 2 with a value pending
    wait_ft(0, "t6_ft");
    step(1);
    if_m.valid_a = 1'b1; if_m.data_a = 16'h4321; if_m.dp_a = 4'hF;
    step(1);
    if_m.valid_a = 1'b0;
    #1 chk("t6_pend", 16'(rdy()), 16'h0000);
    step(22);
    chk("t6_dig2", 16'(pins(0)), 16'({4'b1011, 7'h79, 1'b1}));
    rst = 1'b0;
    #1 chk("t6_rst_pins", 16'(pins(0)), 16'(PINS_OFF));
    chk("t6_rst_ft_owner", 16'({frame_tick, owner_b}), 16'h0000);
    chk("t6_rst_ready", 16'(rdy()), 16'h0003);
    step(3);
    rst = 1'b1;
    #1 chk("t6_pend_gone", 16'(rdy()), 16'h0003);
    step(3);
    chk("t6_restart_d0", 16'(pins(0)), 16'({4'b1110, 7'h40, 1'b1}));
    step(37);
    chk("t6_first_ft", 16'(frame_tick), 16'h0001);
    check_frame(0, "t6", 0, {4{7'h40}}, 4'h0, 4'hF);
    chk("t6_owner", 16'(owner_b), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
